stack_ctrl: RTL and testbench
=============================

Name: stack_ctrl

Overview:
- Sequences the 10-bit hardware return stack for two requesters: the core (CALL/RET, one word) and the interrupt controller (entry/RETI, two words: PC then flags).
- Fixed-priority arbiter with a req/ack handshake.
- Owns the stack's enable/operation/data_in pins and tracks occupancy itself, so two-word operations are atomic and never partially executed.

Parameters:
- DEPTH, 16: depth of the attached stack; usable capacity CAP = DEPTH-1 words.
- ADDR_WIDTH, 4: log2(DEPTH); width of the occupancy counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- core_req  in  1  core request, held until core_ack
- core_op  in  1  1 = CALL (push), 0 = RET (pop)
- core_pc  in  10  return address to push
- core_ack  out  1  one-cycle completion pulse
- core_rdata  out  10  popped return address, valid while core_ack=1
- core_err  out  1  with core_ack: request rejected, no stack change
- irq_req  in  1  interrupt request, held until irq_ack
- irq_op  in  1  1 = entry (push PC, flags), 0 = RETI (pop flags, PC)
- irq_pc  in  10  PC to save
- irq_flags  in  10  flags word to save
- irq_ack  out  1  one-cycle completion pulse
- irq_rdata_pc  out  10  restored PC, valid with irq_ack
- irq_rdata_flags  out  10  restored flags, valid with irq_ack
- irq_err  out  1  with irq_ack: rejected
- stk_enable  out  1  to stack enable
- stk_operation  out  1  to stack operation (1 = push)
- stk_data_in  out  10  to stack data_in
- stk_data_out  in  10  from stack; valid the cycle after a pop is issued
- busy  out  1  FSM not in IDLE
- depth  out  ADDR_WIDTH  current occupancy (occ)

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, occ=0; all outputs 0, including rdata registers. Reset mid-operation aborts the operation with no ack. The top level resets the stack from the same source in the same cycle.
- States: IDLE, PUSH_A, PUSH_B, POP_A, POP_B, POP_DONE, RESP.
- IDLE arbitration:
  - irq_req has priority over core_req.
  - Latch winner id, op and operands.
  - Capacity check on occ: CALL needs occ<=CAP-1; entry needs occ<=CAP-2; RET needs occ>=1; RETI needs occ>=2.
  - Check fails: go to RESP with err set; no stack access.
- Stack pins are Moore outputs of state:
  - PUSH_A: enable=1, op=1, data=latched PC.
  - PUSH_B: enable=1, op=1, data=latched flags.
  - POP_A, POP_B: enable=1, op=0, data=0.
  - All other states: enable=0.
- Transitions:
  - CALL: IDLE -> PUSH_A -> RESP.
  - Entry: IDLE -> PUSH_A -> PUSH_B -> RESP.
  - RET: IDLE -> POP_A -> POP_DONE -> RESP.
  - RETI: IDLE -> POP_A -> POP_B -> POP_DONE -> RESP.
  - RESP -> IDLE always.
- Pop capture:
  - RETI: in POP_B, stk_data_out (flags) loads irq_rdata_flags at the cycle end. In POP_DONE, stk_data_out (PC) loads irq_rdata_pc.
  - RET: in POP_DONE, stk_data_out loads core_rdata.
  - rdata holds until the next successful pop for that requester.
- occ: +1 at the end of each PUSH_x cycle, -1 at the end of each POP_x cycle. It never wraps, guaranteed by the capacity check.
- Latency from req seen in IDLE (cycle T) to ack: CALL T+2, entry T+3, RET T+3, RETI T+4, rejected T+1.
- RESP: exactly one of core_ack/irq_ack = 1 for one cycle; err=1 only if rejected.
- Handshake:
  - Requester holds req and operands stable until ack, then drops req on the next cycle.
  - A req still high in IDLE is a new request.
  - A request arriving while busy waits; it is never dropped.
  - Simultaneous requests: irq served first; core served on the following IDLE cycle.

Test Plan:
- Reset, core CALL pc=0x155, then RET -> stk_enable/op=1/data 0x155 in the cycle after IDLE; ack at T+2, depth 1; RET ack at T+3 with core_rdata=0x155, err=0, depth 0.
- irq entry pc=0x2A0 flags=0x00F, then RETI -> two pushes (0x2A0 then 0x00F); RETI ack at T+4 with irq_rdata_pc=0x2A0, irq_rdata_flags=0x00F.
- core_req and irq_req asserted in the same cycle -> irq_ack first, core_ack afterwards; the core's ack arrives only after IDLE is re-entered, with no lost request.
- Fill with 15 CALLs (depth=15) -> 16th CALL acked at T+1 with core_err=1, no stk_enable pulse. At depth=14, irq entry rejected; RET on empty rejected; RETI at depth=1 rejected.
- Assert rst=0 during PUSH_B of an entry -> next cycle: IDLE, depth=0, no ack, all outputs 0; a subsequent CALL completes normally.

Source files
------------

// File: rtl/stack_ctrl_if.sv
// Signal bundle between stack_ctrl, its two requesters and the attached hardware stack.
// The slave modport is the controller's view; master is the requester/stack side.
interface stack_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  core_req;
    logic                  core_op;
    logic [9:0]            core_pc;
    logic                  core_ack;
    logic [9:0]            core_rdata;
    logic                  core_err;
    logic                  irq_req;
    logic                  irq_op;
    logic [9:0]            irq_pc;
    logic [9:0]            irq_flags;
    logic                  irq_ack;
    logic [9:0]            irq_rdata_pc;
    logic [9:0]            irq_rdata_flags;
    logic                  irq_err;
    logic                  stk_enable;
    logic                  stk_operation;
    logic [9:0]            stk_data_in;
    logic [9:0]            stk_data_out;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] depth;

    modport slave (
        input  core_req, core_op, core_pc, irq_req, irq_op, irq_pc, irq_flags, stk_data_out,
        output core_ack, core_rdata, core_err, irq_ack, irq_rdata_pc, irq_rdata_flags, irq_err,
               stk_enable, stk_operation, stk_data_in, busy, depth
    );

    modport master (
        output core_req, core_op, core_pc, irq_req, irq_op, irq_pc, irq_flags, stk_data_out,
        input  core_ack, core_rdata, core_err, irq_ack, irq_rdata_pc, irq_rdata_flags, irq_err,
               stk_enable, stk_operation, stk_data_in, busy, depth
    );
endinterface

// File: rtl/stack_ctrl.sv
// Return-stack sequencer: arbitrates core CALL/RET and interrupt entry/RETI onto one stack,
// tracking occupancy so that two-word interrupt frames are pushed/popped atomically.
module stack_ctrl #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input logic         clk,
    input logic         rst,
    stack_ctrl_if.slave bus
);
    localparam int unsigned Cap = DEPTH - 1;
    localparam logic [ADDR_WIDTH-1:0] CapM1 = ADDR_WIDTH'(Cap - 1);
    localparam logic [ADDR_WIDTH-1:0] CapM2 = ADDR_WIDTH'(Cap - 2);

    typedef enum logic [2:0] {
        StIdle, StPushA, StPushB, StPopA, StPopB, StPopDone, StResp
    } state_e;

    state_e                state_q, state_d;
    logic                  is_irq_q, is_irq_d;
    logic                  op_q, op_d;
    logic                  err_q, err_d;
    logic [9:0]            pc_q, pc_d;
    logic [9:0]            flags_q, flags_d;
    logic [ADDR_WIDTH-1:0] occ_q, occ_d;
    logic [9:0]            core_rdata_q, core_rdata_d;
    logic [9:0]            irq_pc_q, irq_pc_d;
    logic [9:0]            irq_flags_q, irq_flags_d;
    logic                  sel_op;
    logic                  cap_ok;

    always_comb begin
        state_d           = state_q;
        is_irq_d          = is_irq_q;
        op_d              = op_q;
        err_d             = err_q;
        pc_d              = pc_q;
        flags_d           = flags_q;
        occ_d             = occ_q;
        core_rdata_d      = core_rdata_q;
        irq_pc_d          = irq_pc_q;
        irq_flags_d       = irq_flags_q;
        bus.stk_enable    = 1'b0;
        bus.stk_operation = 1'b0;
        bus.stk_data_in   = '0;

        // irq wins arbitration; capacity is judged against the winner's word count
        sel_op = bus.irq_req ? bus.irq_op : bus.core_op;
        if (sel_op) begin
            cap_ok = bus.irq_req ? (occ_q <= CapM2) : (occ_q <= CapM1);
        end else begin
            cap_ok = bus.irq_req ? (occ_q >= ADDR_WIDTH'(2)) : (occ_q != '0);
        end

        unique case (state_q)
            StIdle: begin
                err_d = 1'b0;
                if (bus.irq_req || bus.core_req) begin
                    is_irq_d = bus.irq_req;
                    op_d     = sel_op;
                    pc_d     = bus.irq_req ? bus.irq_pc : bus.core_pc;
                    flags_d  = bus.irq_flags;
                    if (!cap_ok) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = sel_op ? StPushA : StPopA;
                    end
                end
            end
            StPushA: begin
                bus.stk_enable    = 1'b1;
                bus.stk_operation = 1'b1;
                bus.stk_data_in   = pc_q;
                occ_d             = occ_q + ADDR_WIDTH'(1);
                state_d           = is_irq_q ? StPushB : StResp;
            end
            StPushB: begin
                bus.stk_enable    = 1'b1;
                bus.stk_operation = 1'b1;
                bus.stk_data_in   = flags_q;
                occ_d             = occ_q + ADDR_WIDTH'(1);
                state_d           = StResp;
            end
            StPopA: begin
                bus.stk_enable = 1'b1;
                occ_d          = occ_q - ADDR_WIDTH'(1);
                state_d        = is_irq_q ? StPopB : StPopDone;
            end
            StPopB: begin
                // data_out now holds the flags word popped in StPopA
                bus.stk_enable = 1'b1;
                occ_d          = occ_q - ADDR_WIDTH'(1);
                irq_flags_d    = bus.stk_data_out;
                state_d        = StPopDone;
            end
            StPopDone: begin
                if (is_irq_q) begin
                    irq_pc_d = bus.stk_data_out;
                end else begin
                    core_rdata_d = bus.stk_data_out;
                end
                state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            is_irq_q     <= 1'b0;
            op_q         <= 1'b0;
            err_q        <= 1'b0;
            pc_q         <= '0;
            flags_q      <= '0;
            occ_q        <= '0;
            core_rdata_q <= '0;
            irq_pc_q     <= '0;
            irq_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            is_irq_q     <= is_irq_d;
            op_q         <= op_d;
            err_q        <= err_d;
            pc_q         <= pc_d;
            flags_q      <= flags_d;
            occ_q        <= occ_d;
            core_rdata_q <= core_rdata_d;
            irq_pc_q     <= irq_pc_d;
            irq_flags_q  <= irq_flags_d;
        end
    end

    assign bus.core_ack        = (state_q == StResp) && !is_irq_q;
    assign bus.irq_ack         = (state_q == StResp) && is_irq_q;
    assign bus.core_err        = bus.core_ack && err_q;
    assign bus.irq_err         = bus.irq_ack && err_q;
    assign bus.core_rdata      = core_rdata_q;
    assign bus.irq_rdata_pc    = irq_pc_q;
    assign bus.irq_rdata_flags = irq_flags_q;
    assign bus.busy            = (state_q != StIdle);
    assign bus.depth           = occ_q;

    logic unused_op;
    assign unused_op = op_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: behavioural LIFO stack device on the stack pins plus a queue-based
// reference model of the return stack, exercised by directed scenarios and random traffic.
module tb_stack_ctrl;
    localparam int unsigned DEPTH      = 16;
    localparam int unsigned ADDR_WIDTH = 4;
    localparam int          Cap        = DEPTH - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stack_ctrl_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    stack_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Attached stack device: push writes, pop presents the word on data_out next cycle.
    logic [9:0] stk_mem [0:31];
    logic [4:0] stk_sp;
    always @(posedge clk) begin
        if (!rst) begin
            stk_sp           <= '0;
            bus.stk_data_out <= '0;
        end else if (bus.stk_enable) begin
            if (bus.stk_operation) begin
                stk_mem[stk_sp] <= bus.stk_data_in;
                stk_sp          <= stk_sp + 5'd1;
            end else begin
                bus.stk_data_out <= stk_mem[stk_sp - 5'd1];
                stk_sp           <= stk_sp - 5'd1;
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [9:0] ref_stk[$];
    logic [9:0] exp_push[$];
    int         exp_pops;
    logic [9:0] exp_core_rdata, exp_irq_pc, exp_irq_fl;

    // Observations from the last drive()
    logic [9:0] obs_push[$];
    int         obs_pops, obs_first_en, obs_extra;

    task automatic new_step();
        exp_push.delete();
        exp_pops = 0;
    endtask

    task automatic model_txn(input bit is_irq, input bit op, input logic [9:0] pc,
                             input logic [9:0] fl, output bit ok, output int lat);
        int words;
        words = is_irq ? 2 : 1;
        ok = op ? (ref_stk.size() + words <= Cap) : (ref_stk.size() >= words);
        if (!ok) lat = 1;
        else if (is_irq) lat = op ? 3 : 4;
        else lat = op ? 2 : 3;
        if (ok) begin
            if (op) begin
                ref_stk.push_back(pc);
                exp_push.push_back(pc);
                if (is_irq) begin
                    ref_stk.push_back(fl);
                    exp_push.push_back(fl);
                end
            end else if (is_irq) begin
                exp_irq_fl = ref_stk.pop_back();
                exp_irq_pc = ref_stk.pop_back();
                exp_pops += 2;
            end else begin
                exp_core_rdata = ref_stk.pop_back();
                exp_pops += 1;
            end
        end
    endtask

    task automatic model_reset();
        ref_stk.delete();
        exp_core_rdata = '0;
        exp_irq_pc     = '0;
        exp_irq_fl     = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        bus.core_req = 1'b0;
        bus.irq_req  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
    endtask

    // Issue requests in an IDLE cycle and collect latencies (cycles after the request cycle).
    task automatic drive(input bit do_core, input bit c_op, input logic [9:0] c_pc,
                         input bit do_irq, input bit i_op, input logic [9:0] i_pc,
                         input logic [9:0] i_fl, output int c_lat, output int i_lat,
                         output logic c_err, output logic i_err);
        int cyc;
        @(posedge clk); #1;
        bus.core_req  = do_core;
        bus.core_op   = c_op;
        bus.core_pc   = c_pc;
        bus.irq_req   = do_irq;
        bus.irq_op    = i_op;
        bus.irq_pc    = i_pc;
        bus.irq_flags = i_fl;
        obs_push.delete();
        obs_pops = 0; obs_first_en = -1; obs_extra = 0;
        c_lat = -1; i_lat = -1; c_err = 1'b0; i_err = 1'b0; cyc = 0;
        while (((do_core && c_lat < 0) || (do_irq && i_lat < 0)) && cyc < 40) begin
            @(negedge clk);
            if (bus.stk_enable) begin
                if (obs_first_en < 0) obs_first_en = cyc;
                if (bus.stk_operation) obs_push.push_back(bus.stk_data_in);
                else obs_pops++;
            end
            if (bus.core_ack) begin
                if (do_core && c_lat < 0) begin
                    c_lat = cyc; c_err = bus.core_err; bus.core_req = 1'b0;
                end else obs_extra++;
            end
            if (bus.irq_ack) begin
                if (do_irq && i_lat < 0) begin
                    i_lat = cyc; i_err = bus.irq_err; bus.irq_req = 1'b0;
                end else obs_extra++;
            end
            cyc++;
        end
        bus.core_req = 1'b0;
        bus.irq_req  = 1'b0;
    endtask

    function automatic bit push_seq_ok();
        bit ok;
        ok = (obs_push.size() == exp_push.size());
        for (int i = 0; i < obs_push.size(); i++)
            if (ok && obs_push[i] !== exp_push[i]) ok = 0;
        return ok;
    endfunction

    task automatic test_reset();
        logic [9:0] z10;
        rst = 1'b0;
        bus.core_req = 0; bus.core_op = 0; bus.core_pc = '0;
        bus.irq_req = 0; bus.irq_op = 0; bus.irq_pc = '0; bus.irq_flags = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        z10 = '0;
        vectors++;
        if ({bus.busy, bus.core_ack, bus.irq_ack, bus.core_err, bus.irq_err} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, required 00000",
                     {bus.busy, bus.core_ack, bus.irq_ack, bus.core_err, bus.irq_err});
        end
        vectors++;
        if (bus.depth !== '0) begin
            miscompares++; $display("FAIL reset_depth: got %0d, required 0", bus.depth);
        end
        vectors++;
        if ({bus.stk_enable, bus.stk_operation, bus.stk_data_in} !== {2'b00, z10}) begin
            miscompares++;
            $display("FAIL reset_stk_pins: got en=%b op=%b data=%h, required 0 0 000",
                     bus.stk_enable, bus.stk_operation, bus.stk_data_in);
        end
        vectors++;
        if ({bus.core_rdata, bus.irq_rdata_pc, bus.irq_rdata_flags} !== {z10, z10, z10}) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h %h %h, required 000 000 000",
                     bus.core_rdata, bus.irq_rdata_pc, bus.irq_rdata_flags);
        end
        @(posedge clk); #1 rst = 1'b1;
        model_reset();
    endtask

    task automatic test_call_ret();
        bit ok; int lat, cl, il; logic ce, ie;
        new_step();
        model_txn(0, 1, 10'h155, '0, ok, lat);
        drive(1, 1, 10'h155, 0, 0, '0, '0, cl, il, ce, ie);
        vectors++;
        if (cl !== 2 || ce !== 1'b0) begin
            miscompares++; $display("FAIL call_ack: got lat=%0d err=%b, required lat=2 err=0", cl, ce);
        end
        vectors++;
        if (obs_first_en !== 1 || !push_seq_ok()) begin
            miscompares++;
            $display("FAIL call_push: got first_en=%0d words=%0d, required first_en=1 word 155",
                     obs_first_en, obs_push.size());
        end
        vectors++;
        if (bus.depth !== 4'd1) begin
            miscompares++; $display("FAIL call_depth: got %0d, required 1", bus.depth);
        end
        new_step();
        model_txn(0, 0, '0, '0, ok, lat);
        drive(1, 0, '0, 0, 0, '0, '0, cl, il, ce, ie);
        vectors++;
        if (cl !== 3 || ce !== 1'b0 || bus.core_rdata !== 10'h155) begin
            miscompares++;
            $display("FAIL ret_ack: got lat=%0d err=%b rdata=%h, required lat=3 err=0 rdata=155",
                     cl, ce, bus.core_rdata);
        end
        vectors++;
        if (bus.depth !== 4'd0 || obs_pops !== exp_pops) begin
            miscompares++;
            $display("FAIL ret_depth: got depth=%0d pops=%0d, required 0 and %0d",
                     bus.depth, obs_pops, exp_pops);
        end
    endtask

    task automatic test_irq_frame();
        bit ok; int lat, cl, il; logic ce, ie;
        new_step();
        model_txn(1, 1, 10'h2A0, 10'h00F, ok, lat);
        drive(0, 0, '0, 1, 1, 10'h2A0, 10'h00F, cl, il, ce, ie);
        vectors++;
        if (il !== 3 || ie !== 1'b0 || !push_seq_ok() || obs_first_en !== 1) begin
            miscompares++;
            $display("FAIL entry: got lat=%0d err=%b words=%0d, required lat=3 err=0 2A0,00F",
                     il, ie, obs_push.size());
        end
        new_step();
        model_txn(1, 0, '0, '0, ok, lat);
        drive(0, 0, '0, 1, 0, '0, '0, cl, il, ce, ie);
        vectors++;
        if (il !== 4 || ie !== 1'b0 || bus.irq_rdata_pc !== 10'h2A0 ||
            bus.irq_rdata_flags !== 10'h00F) begin
            miscompares++;
            $display("FAIL reti: got lat=%0d err=%b pc=%h fl=%h, required lat=4 err=0 2A0 00F",
                     il, ie, bus.irq_rdata_pc, bus.irq_rdata_flags);
        end
        vectors++;
        if (bus.depth !== 4'd0) begin
            miscompares++; $display("FAIL reti_depth: got %0d, required 0", bus.depth);
        end
    endtask

    task automatic test_simultaneous();
        bit oki, okc; int li, lc, cl, il; logic ce, ie;
        new_step();
        model_txn(1, 1, 10'h111, 10'h222, oki, li);
        model_txn(0, 1, 10'h333, '0, okc, lc);
        drive(1, 1, 10'h333, 1, 1, 10'h111, 10'h222, cl, il, ce, ie);
        vectors++;
        if (il !== li || cl !== li + 1 + lc || obs_extra !== 0) begin
            miscompares++;
            $display("FAIL simul_order: got irq=%0d core=%0d extra=%0d, required irq=%0d core=%0d",
                     il, cl, obs_extra, li, li + 1 + lc);
        end
        vectors++;
        if (!push_seq_ok() || bus.depth !== 4'd3) begin
            miscompares++;
            $display("FAIL simul_push: got words=%0d depth=%0d, required 111,222,333 depth 3",
                     obs_push.size(), bus.depth);
        end
    endtask

    task automatic test_capacity();
        bit ok; int lat, cl, il; logic ce, ie;
        do_reset();
        new_step(); model_txn(0, 0, '0, '0, ok, lat);
        drive(1, 0, '0, 0, 0, '0, '0, cl, il, ce, ie);
        vectors++;
        if (cl !== 1 || ce !== 1'b1 || obs_first_en !== -1 || bus.depth !== 4'd0) begin
            miscompares++;
            $display("FAIL ret_empty: got lat=%0d err=%b en=%0d, required lat=1 err=1 no enable",
                     cl, ce, obs_first_en);
        end
        new_step(); model_txn(0, 1, 10'h001, '0, ok, lat);
        drive(1, 1, 10'h001, 0, 0, '0, '0, cl, il, ce, ie);
        new_step(); model_txn(1, 0, '0, '0, ok, lat);
        drive(0, 0, '0, 1, 0, '0, '0, cl, il, ce, ie);
        vectors++;
        if (il !== 1 || ie !== 1'b1 || obs_first_en !== -1 || bus.depth !== 4'd1) begin
            miscompares++;
            $display("FAIL reti_depth1: got lat=%0d err=%b en=%0d depth=%0d, required 1 1 none 1",
                     il, ie, obs_first_en, bus.depth);
        end
        for (int i = 2; i <= 14; i++) begin
            new_step(); model_txn(0, 1, 10'(i), '0, ok, lat);
            drive(1, 1, 10'(i), 0, 0, '0, '0, cl, il, ce, ie);
        end
        vectors++;
        if (bus.depth !== 4'd14 || ce !== 1'b0) begin
            miscompares++; $display("FAIL fill_14: got depth=%0d, required 14", bus.depth);
        end
        new_step(); model_txn(1, 1, 10'h3FF, 10'h3FE, ok, lat);
        drive(0, 0, '0, 1, 1, 10'h3FF, 10'h3FE, cl, il, ce, ie);
        vectors++;
        if (il !== 1 || ie !== 1'b1 || obs_first_en !== -1 || bus.depth !== 4'd14) begin
            miscompares++;
            $display("FAIL entry_depth14: got lat=%0d err=%b en=%0d, required lat=1 err=1 none",
                     il, ie, obs_first_en);
        end
        new_step(); model_txn(0, 1, 10'h00F, '0, ok, lat);
        drive(1, 1, 10'h00F, 0, 0, '0, '0, cl, il, ce, ie);
        vectors++;
        if (cl !== 2 || ce !== 1'b0 || bus.depth !== 4'd15) begin
            miscompares++;
            $display("FAIL call_15: got lat=%0d err=%b depth=%0d, required 2 0 15",
                     cl, ce, bus.depth);
        end
        new_step(); model_txn(0, 1, 10'h010, '0, ok, lat);
        drive(1, 1, 10'h010, 0, 0, '0, '0, cl, il, ce, ie);
        vectors++;
        if (cl !== 1 || ce !== 1'b1 || obs_first_en !== -1 || bus.depth !== 4'd15) begin
            miscompares++;
            $display("FAIL call_full: got lat=%0d err=%b en=%0d depth=%0d, required 1 1 none 15",
                     cl, ce, obs_first_en, bus.depth);
        end
    endtask

    task automatic test_random();
        bit oki, okc; int li, lc, cl, il, mode; logic ce, ie;
        bit c_op, i_op; logic [9:0] c_pc, i_pc, i_fl;
        for (int n = 0; n < 150; n++) begin
            mode = $urandom_range(0, 2);
            c_op = 1'($urandom_range(0, 1)); i_op = 1'($urandom_range(0, 1));
            c_pc = 10'($urandom); i_pc = 10'($urandom); i_fl = 10'($urandom);
            new_step();
            li = -1; lc = -1; oki = 0; okc = 0;
            if (mode != 0) model_txn(1, i_op, i_pc, i_fl, oki, li);
            if (mode != 1) model_txn(0, c_op, c_pc, '0, okc, lc);
            if (mode == 2) lc = li + 1 + lc;
            drive(mode != 1, c_op, c_pc, mode != 0, i_op, i_pc, i_fl, cl, il, ce, ie);
            vectors++;
            if (cl !== lc || il !== li || obs_extra !== 0) begin
                miscompares++;
                $display("FAIL rand_lat[%0d]: got core=%0d irq=%0d extra=%0d, required %0d %0d 0",
                         n, cl, il, obs_extra, lc, li);
            end
            vectors++;
            if ((mode != 1 && ce !== !okc) || (mode != 0 && ie !== !oki)) begin
                miscompares++;
                $display("FAIL rand_err[%0d]: got core=%b irq=%b, required core=%b irq=%b",
                         n, ce, ie, !okc, !oki);
            end
            vectors++;
            if (!push_seq_ok() || obs_pops !== exp_pops || bus.depth !== ADDR_WIDTH'(ref_stk.size())) begin
                miscompares++;
                $display("FAIL rand_stack[%0d]: got words=%0d pops=%0d depth=%0d, required %0d %0d %0d",
                         n, obs_push.size(), obs_pops, bus.depth, exp_push.size(), exp_pops,
                         ref_stk.size());
            end
            vectors++;
            if (bus.core_rdata !== exp_core_rdata || bus.irq_rdata_pc !== exp_irq_pc ||
                bus.irq_rdata_flags !== exp_irq_fl) begin
                miscompares++;
                $display("FAIL rand_rdata[%0d]: got %h %h %h, required %h %h %h", n,
                         bus.core_rdata, bus.irq_rdata_pc, bus.irq_rdata_flags,
                         exp_core_rdata, exp_irq_pc, exp_irq_fl);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        bit ok; int lat, cl, il, acks; logic ce, ie;
        do_reset();
        new_step(); model_txn(0, 1, 10'h3C3, '0, ok, lat);
        drive(1, 1, 10'h3C3, 0, 0, '0, '0, cl, il, ce, ie);
        new_step(); model_txn(0, 0, '0, '0, ok, lat);
        drive(1, 0, '0, 0, 0, '0, '0, cl, il, ce, ie);
        @(posedge clk); #1;
        bus.irq_req = 1'b1; bus.irq_op = 1'b1; bus.irq_pc = 10'h0F0; bus.irq_flags = 10'h1E1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.stk_enable !== 1'b1 || bus.stk_data_in !== 10'h1E1) begin
            miscompares++;
            $display("FAIL mid_push_b: got en=%b data=%h, required 1 1E1",
                     bus.stk_enable, bus.stk_data_in);
        end
        rst = 1'b0; bus.irq_req = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        model_reset();
        @(negedge clk);
        vectors++;
        if ({bus.busy, bus.core_ack, bus.irq_ack, bus.stk_enable, bus.depth} !== '0 ||
            {bus.core_rdata, bus.irq_rdata_pc, bus.irq_rdata_flags} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_outs: got busy=%b ack=%b%b en=%b depth=%0d rdata=%h, required 0",
                     bus.busy, bus.core_ack, bus.irq_ack, bus.stk_enable, bus.depth, bus.core_rdata);
        end
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.core_ack || bus.irq_ack || bus.busy) acks++;
        end
        vectors++;
        if (acks !== 0) begin
            miscompares++; $display("FAIL mid_reset_noack: got %0d active cycles, required 0", acks);
        end
        new_step(); model_txn(0, 1, 10'h0AA, '0, ok, lat);
        drive(1, 1, 10'h0AA, 0, 0, '0, '0, cl, il, ce, ie);
        vectors++;
        if (cl !== 2 || ce !== 1'b0 || !push_seq_ok() || bus.depth !== 4'd1) begin
            miscompares++;
            $display("FAIL after_reset_call: got lat=%0d err=%b depth=%0d, required 2 0 1",
                     cl, ce, bus.depth);
        end
        new_step(); model_txn(0, 0, '0, '0, ok, lat);
        drive(1, 0, '0, 0, 0, '0, '0, cl, il, ce, ie);
        vectors++;
        if (cl !== 3 || bus.core_rdata !== 10'h0AA) begin
            miscompares++;
            $display("FAIL after_reset_ret: got lat=%0d rdata=%h, required 3 0AA", cl, bus.core_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_call_ret();
        test_irq_frame();
        test_simultaneous();
        test_capacity();
        test_random();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end
endmodule
